uart_fifo_core: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo_core_sync_fifo.sv | 52 +++++
 rtl/uart_fifo_core.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: FSM state encoding, parity modes and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Parity bit that makes the low nbits of word plus the bit itself odd/even.
    function automatic logic parity_bit(input logic [7:0] word, input int nbits, input int mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) x ^= word[i];
        end
        return (mode == PARITY_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_fifo_core_sync_fifo.sv
// Synchronous FIFO with extra pointer MSB to tell full from empty; read data reads 0 when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_push = wr_en_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_fifo_core.sv
// UART with RX/TX shifters and FIFOs behind valid/ready streams.
// Define UART_ECHO_EN to loop every accepted RX byte back into the TX FIFO.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RXD,
    output logic                 TXD,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_err,
    output logic                 tx_busy
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic             PAR_EN    = (PARITY != PARITY_NONE);

    logic rxd_meta_q, rxd_sync_q;

    uart_state_e          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_ok_q, rx_par_ok_d;
    logic                 rx_done, rx_frame_ok, rx_push, rx_pop, rx_full, rx_empty;
    logic                 rx_err_q, rx_ovr_q;

    uart_state_e          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_load, tx_pop, tx_wr, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_wdata, tx_head;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // RX: START samples mid-bit, every later sample is one bit period on.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_par_ok_d = rx_par_ok_q;
        rx_done     = 1'b0;
        rx_frame_ok = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (!rxd_sync_q) rx_state_d = ST_START;
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d    = '0;
                    rx_idx_d    = '0;
                    rx_par_ok_d = 1'b1;
                    rx_state_d  = rxd_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == DATA_LAST) rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    else                       rx_idx_d   = rx_idx_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d    = '0;
                    rx_par_ok_d = (rxd_sync_q == parity_bit(8'(rx_shift_q), DATA_BITS, PARITY));
                    rx_state_d  = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d    = '0;
                    rx_done     = 1'b1;
                    rx_frame_ok = rxd_sync_q && rx_par_ok_q;
                    rx_state_d  = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_ok_q <= 1'b1;
            rx_err_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_ok_q <= rx_par_ok_d;
            rx_err_q    <= rx_done && !rx_frame_ok;
            rx_ovr_q    <= rx_done && rx_frame_ok && rx_full && !rx_pop;
        end
    end

    assign rx_pop     = rx_valid && rx_ready;
    assign rx_push    = rx_done && rx_frame_ok && (!rx_full || rx_pop);
    assign rx_valid   = !rx_empty;
    assign rx_err     = rx_err_q;
    assign rx_overrun = rx_ovr_q;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en_i  (rx_push),
        .wr_data_i(rx_shift_q),
        .rd_en_i  (rx_pop),
        .rd_data_o(rx_data),
        .full_o   (rx_full),
        .empty_o  (rx_empty)
    );

`ifdef UART_ECHO_EN
    assign tx_ready = !tx_full && !rx_push;
    assign tx_wr    = rx_push || (tx_valid && tx_ready);
    assign tx_wdata = rx_push ? rx_shift_q : tx_data;
`else
    assign tx_ready = !tx_full;
    assign tx_wr    = tx_valid && tx_ready;
    assign tx_wdata = tx_data;
`endif

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en_i  (tx_wr),
        .wr_data_i(tx_wdata),
        .rd_en_i  (tx_pop),
        .rd_data_o(tx_head),
        .full_o   (tx_full),
        .empty_o  (tx_empty)
    );

    // TX: txd is registered; loading straight out of STOP gives back-to-back frames.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                txd_d   = 1'b1;
                tx_load = !tx_empty;
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_state_d = ST_DATA;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == DATA_LAST) begin
                        tx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
                        txd_d      = PAR_EN ? tx_par_q : 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                    tx_load    = !tx_empty;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = parity_bit(8'(tx_head), DATA_BITS, PARITY);
            tx_cnt_d   = '0;
            tx_state_d = ST_START;
            txd_d      = 1'b0;
        end
    end

    // NOTE: sequential state uses <= only, so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    assign TXD     = txd_q;
    assign tx_busy = (tx_state_q != ST_IDLE) || !tx_empty;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench: dut0 is a no-parity UART with 4-deep FIFOs, dut1 uses even parity.
module tb_uart_fifo_core;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic       rxd0, txd0, tx_valid0, tx_ready0, rx_valid0, rx_ready0, rx_overrun0, rx_err0, tx_busy0;
    logic [7:0] tx_data0, rx_data0;
    logic       rxd1, txd1, tx_valid1, tx_ready1, rx_valid1, rx_ready1, rx_overrun1, rx_err1, tx_busy1;
    logic [7:0] tx_data1, rx_data1;

    uart_fifo_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .RX_DEPTH(4), .TX_DEPTH(4)) dut0 (
        .CLK(CLK), .RST(RST), .RXD(rxd0), .TXD(txd0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .rx_overrun(rx_overrun0), .rx_err(rx_err0), .tx_busy(tx_busy0)
    );

    uart_fifo_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .RX_DEPTH(4), .TX_DEPTH(4)) dut1 (
        .CLK(CLK), .RST(RST), .RXD(rxd1), .TXD(txd1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .rx_overrun(rx_overrun1), .rx_err(rx_err1), .tx_busy(tx_busy1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc0 = -1;
    int err_cnt0 = 0, err_cnt1 = 0, ovr_cnt0 = 0, txd0_low = 0;
    logic prev_valid0 = 1'b0;

    // Monitors sample at posedge, i.e. the value held during the cycle just ending.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (rx_err0)     err_cnt0 <= err_cnt0 + 1;
        if (rx_err1)     err_cnt1 <= err_cnt1 + 1;
        if (rx_overrun0) ovr_cnt0 <= ovr_cnt0 + 1;
        if (!txd0)       txd0_low <= txd0_low + 1;
        if (rx_valid0 && !prev_valid0) rise_cyc0 <= cyc;
        prev_valid0 <= rx_valid0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rxd0 = b;
        else            rxd1 = b;
        repeat (16) @(negedge CLK);
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input logic use_par, input logic par);
        start_cyc = cyc;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
        if (use_par) drive_bit(which, par);
        drive_bit(which, 1'b1);
    endtask

    task automatic pop0();
        rx_ready0 = 1'b1;
        @(negedge CLK);
        rx_ready0 = 1'b0;
    endtask

    initial begin
        logic [9:0] fr;
        int base;

        RST = 1'b1;
        rxd0 = 1'b1; rxd1 = 1'b1;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0;
        tx_data0 = 8'h00; tx_data1 = 8'h00;
        rx_ready0 = 1'b0; rx_ready1 = 1'b0;
        repeat (3) @(negedge CLK);

        check("rst_txd",      txd0,        1);
        check("rst_tx_ready", tx_ready0,   1);
        check("rst_rx_valid", rx_valid0,   0);
        check("rst_rx_data",  rx_data0,    0);
        check("rst_overrun",  rx_overrun0, 0);
        check("rst_rx_err",   rx_err0,     0);
        check("rst_tx_busy",  tx_busy0,    0);
        check("rst_txd1",     txd1,        1);
        RST = 1'b0;
        @(negedge CLK);

        // TX 0xA5: start, LSB-first data, stop; first and last cycle of every bit.
        tx_data0 = 8'hA5;
        tx_valid0 = 1'b1;
        @(negedge CLK);
        tx_valid0 = 1'b0;
        check("tx_busy_queued", tx_busy0, 1);
        check("tx_idle_before", txd0, 1);
        @(negedge CLK);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 16; j++) begin
                if (j == 0 || j == 15) check($sformatf("txd_bit%0d_c%0d", i, j), txd0, fr[i]);
                if (i == 9 && j == 15) check("tx_busy_last", tx_busy0, 1);
                @(negedge CLK);
            end
        end
        check("tx_busy_done", tx_busy0, 0);
        check("txd_idle_after", txd0, 1);

        // Start-bit glitch shorter than half a bit.
        rxd0 = 1'b0;
        repeat (4) @(negedge CLK);
        rxd0 = 1'b1;
        repeat (200) @(negedge CLK);
        check("glitch_rx_valid", rx_valid0, 0);
        check("glitch_rx_err", err_cnt0, 0);

        // RX 0x3C with the consumer stalled.
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        check("rx_latency", rise_cyc0 - start_cyc, 155);
        check("rx_valid_3c", rx_valid0, 1);
        check("rx_data_3c", rx_data0, 8'h3C);
        repeat (5) @(negedge CLK);
        check("rx_data_stable", rx_data0, 8'h3C);
        pop0();
        check("rx_valid_popped", rx_valid0, 0);
        check("rx_err_none", err_cnt0, 0);

        // Overrun: 4-deep FIFO, five frames, no draining.
        for (int v = 1; v <= 4; v++) send_frame(0, 8'(v), 1'b0, 1'b0);
        check("ovr_before_5th", ovr_cnt0, 0);
        send_frame(0, 8'h05, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        check("ovr_after_5th", ovr_cnt0, 1);
        check("ovr_no_err", err_cnt0, 0);
        for (int v = 1; v <= 4; v++) begin
            check($sformatf("drain_valid_%0d", v), rx_valid0, 1);
            check($sformatf("drain_data_%0d", v), rx_data0, v);
            pop0();
        end
        check("drain_empty", rx_valid0, 0);

        // Even parity on dut1: 0x07 needs parity bit 1.
        send_frame(1, 8'h07, 1'b1, 1'b0);
        check("par_bad_err", err_cnt1, 1);
        check("par_bad_no_push", rx_valid1, 0);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        check("par_good_valid", rx_valid1, 1);
        check("par_good_data", rx_data1, 8'h07);
        check("par_good_no_err", err_cnt1, 1);

        // Reset in the middle of a TX frame with a second byte queued.
        tx_data0 = 8'h00;
        tx_valid0 = 1'b1;
        @(negedge CLK);
        tx_data0 = 8'h81;
        @(negedge CLK);
        tx_valid0 = 1'b0;
        repeat (40) @(negedge CLK);
        check("midtx_txd_low", txd0, 0);
        check("midtx_busy", tx_busy0, 1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_txd", txd0, 1);
        check("midrst_busy", tx_busy0, 0);
        check("midrst_ready", tx_ready0, 1);
        RST = 1'b0;
        repeat (50) @(negedge CLK);
        check("postrst_txd", txd0, 1);
        check("postrst_busy", tx_busy0, 0);

        // Echo path: a received byte replays on TXD only when enabled.
        base = txd0_low;
        send_frame(0, 8'h55, 1'b0, 1'b0);
        check("echo_rx_data", rx_data0, 8'h55);
        repeat (200) @(negedge CLK);
`ifdef UART_ECHO_EN
        check("echo_txd_active", (txd0_low - base) == 80, 1);
`else
        check("echo_txd_quiet", txd0_low - base, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
